// File: rtl/bitstream_loader.sv
// Streams a word-wide configuration image LSB-first to FPGACore on io_dta/io_den,
// then issues a one-cycle io_reset pulse to clear the lookup tables.
module bitstream_loader #(
    parameter int unsigned BITS   = 10080,
    parameter int unsigned WORD_W = 16,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_data,
    output logic              io_dta,
    output logic              io_den,
    output logic              io_reset,
    output logic              busy,
    output logic              done
);
    localparam int unsigned NWORDS = (BITS + WORD_W - 1) / WORD_W;
    localparam int unsigned BCW    = $clog2(BITS + 1);
    localparam int unsigned WCW    = $clog2(NWORDS + 1);
    localparam int unsigned PCW    = $clog2(WORD_W);

    typedef enum logic [2:0] {IDLE, FETCH, PRIME, SHIFT, PULSE} state_e;

    state_e             state_q, state_d;
    logic [BCW-1:0]     bit_q, bit_d;
    logic [WCW-1:0]     word_q, word_d;
    logic [PCW-1:0]     pos_q, pos_d;
    logic [WORD_W-1:0]  sr_q, sr_d;
    logic [WORD_W-1:0]  hold_q, hold_d;
    logic               rd_pend_q, rd_pend_d;
    logic               mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               io_dta_q, io_dta_d;
    logic               io_den_q, io_den_d;
    logic               io_reset_q, io_reset_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               last_bit;
    logic               word_end;
    logic [WORD_W-1:0]  next_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            word_q     <= '0;
            pos_q      <= '0;
            sr_q       <= '0;
            hold_q     <= '0;
            rd_pend_q  <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            io_dta_q   <= 1'b0;
            io_den_q   <= 1'b0;
            io_reset_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            word_q     <= word_d;
            pos_q      <= pos_d;
            sr_q       <= sr_d;
            hold_q     <= hold_d;
            rd_pend_q  <= rd_pend_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            io_dta_q   <= io_dta_d;
            io_den_q   <= io_den_d;
            io_reset_q <= io_reset_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        word_d     = word_q;
        pos_d      = pos_q;
        sr_d       = sr_q;
        hold_d     = hold_q;
        rd_pend_d  = mem_rd_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        io_dta_d   = io_dta_q;
        io_den_d   = io_den_q;
        io_reset_d = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        last_bit   = (32'(bit_q) == BITS - 1);
        word_end   = (32'(pos_q) == WORD_W - 1);
        // A read issued last cycle has data on the bus now; bypass the holding register.
        next_word  = rd_pend_q ? mem_data : hold_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d    = FETCH;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = '0;
                    bit_d      = '0;
                    word_d     = '0;
                    pos_d      = '0;
                end
            end
            FETCH: state_d = PRIME;
            PRIME: begin
                state_d  = SHIFT;
                io_den_d = 1'b1;
                io_dta_d = mem_data[0];
                sr_d     = mem_data >> 1;
                if (NWORDS > 1) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = ADDR_W'(1);
                end
            end
            SHIFT: begin
                if (rd_pend_q) hold_d = mem_data;
                if (last_bit) begin
                    state_d    = PULSE;
                    io_den_d   = 1'b0;
                    io_dta_d   = 1'b0;
                    io_reset_d = 1'b1;
                end else begin
                    bit_d = bit_q + BCW'(1);
                    if (word_end) begin
                        pos_d    = '0;
                        word_d   = word_q + WCW'(1);
                        io_dta_d = next_word[0];
                        sr_d     = next_word >> 1;
                        // Prefetch the word after the one now starting, if it exists.
                        if (32'(word_q) + 32'd2 < NWORDS) begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = ADDR_W'(32'(word_q) + 32'd2);
                        end
                    end else begin
                        pos_d    = pos_q + PCW'(1);
                        io_dta_d = sr_q[0];
                        sr_d     = sr_q >> 1;
                    end
                end
            end
            PULSE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d    = IDLE;
            mem_rd_d   = 1'b0;
            rd_pend_d  = 1'b0;
            io_den_d   = 1'b0;
            io_dta_d   = 1'b0;
            io_reset_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
        end
    end

    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign io_dta   = io_dta_q;
    assign io_den   = io_den_q;
    assign io_reset = io_reset_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bitstream_loader.sv
// Scoreboard bench: a full-size loader with a constant image and a 40-bit loader with a
// three-word image; expected serial bits are queued at start and popped by monitors.
module tb_bitstream_loader;
    logic clk;
    logic reset_n;

    logic        start_a, abort_a, mem_rd_a, io_dta_a, io_den_a, io_reset_a, busy_a, done_a;
    logic [9:0]  mem_addr_a;
    logic [15:0] mem_data_a;

    logic        start_b, abort_b, mem_rd_b, io_dta_b, io_den_b, io_reset_b, busy_b, done_b;
    logic [3:0]  mem_addr_b;
    logic [15:0] mem_data_b;

    int n_tests = 0;
    int n_fail  = 0;

    bit exp_a[$];
    bit exp_b[$];

    logic [15:0] w_a    = 16'hA5C3;
    logic [39:0] pat_b  = 40'hFF_8000_0001;
    logic [15:0] img_b [3];

    int rd_cnt_a [630];
    int bad_rd_a, rd_tot_a, den_cnt_a, den_rise_a, rst_hi_a;
    int rd_cnt_b [3];
    int bad_rd_b, den_cnt_b, den_rise_b, rst_hi_b, done_rise_b;
    logic den_prev_a, den_prev_b, done_prev_b;

    bitstream_loader u_dut_a (
        .clk(clk), .reset(reset_n), .start(start_a), .abort(abort_a),
        .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
        .io_dta(io_dta_a), .io_den(io_den_a), .io_reset(io_reset_a),
        .busy(busy_a), .done(done_a)
    );

    bitstream_loader #(.BITS(40), .WORD_W(16), .ADDR_W(4)) u_dut_b (
        .clk(clk), .reset(reset_n), .start(start_b), .abort(abort_b),
        .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
        .io_dta(io_dta_b), .io_den(io_den_b), .io_reset(io_reset_b),
        .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous memories: data appears the cycle after mem_rd
    always @(posedge clk) begin
        if (mem_rd_a) begin
            mem_data_a <= 16'hA5C3;
            rd_tot_a++;
            if (mem_addr_a < 10'd630) rd_cnt_a[mem_addr_a]++;
            else bad_rd_a++;
        end
        if (mem_rd_b) begin
            if (mem_addr_b < 4'd3) begin
                mem_data_b <= img_b[mem_addr_b];
                rd_cnt_b[mem_addr_b]++;
            end else begin
                mem_data_b <= 16'hDEAD;
                bad_rd_b++;
            end
        end
    end

    // Monitors: pop and compare every bit FPGACore would sample
    always @(negedge clk) begin
        if (io_den_a) begin
            den_cnt_a++;
            if (!den_prev_a) den_rise_a++;
            if (exp_a.size() == 0) chk1("a_extra_bit", io_den_a, 1'b0);
            else chk1("a_bit", io_dta_a, exp_a.pop_front());
        end else begin
            chk1("a_dta_idle", io_dta_a, 1'b0);
        end
        if (io_reset_a) begin
            rst_hi_a++;
            chk1("a_reset_vs_den", io_den_a, 1'b0);
        end
        den_prev_a = io_den_a;
    end

    always @(negedge clk) begin
        if (io_den_b) begin
            den_cnt_b++;
            if (!den_prev_b) den_rise_b++;
            if (exp_b.size() == 0) chk1("b_extra_bit", io_den_b, 1'b0);
            else chk1("b_bit", io_dta_b, exp_b.pop_front());
        end else begin
            chk1("b_dta_idle", io_dta_b, 1'b0);
        end
        if (io_reset_b) begin
            rst_hi_b++;
            chk1("b_reset_vs_den", io_den_b, 1'b0);
        end
        if (done_b && !done_prev_b) done_rise_b++;
        den_prev_b  = io_den_b;
        done_prev_b = done_b;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_b();
        den_cnt_b = 0; den_rise_b = 0; rst_hi_b = 0; done_rise_b = 0; bad_rd_b = 0;
        for (int i = 0; i < 3; i++) rd_cnt_b[i] = 0;
    endtask

    task automatic push_b(input int n);
        for (int i = 0; i < n; i++) exp_b.push_back(pat_b[i]);
    endtask

    task automatic pulse_start_b();
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
    endtask

    task automatic wait_done_b(input int lim);
        int c;
        c = 0;
        while (!done_b && c < lim) begin
            tick(1);
            c++;
        end
        chk1("b_done_timeout", done_b, 1'b1);
    endtask

    task automatic check_full_b(input string tag);
        tick(2);
        chk32({tag, "_den_cycles"}, 32'(den_cnt_b), 32'd40);
        chk32({tag, "_den_runs"}, 32'(den_rise_b), 32'd1);
        chk32({tag, "_bits_left"}, 32'(exp_b.size()), 32'd0);
        chk32({tag, "_reset_cycles"}, 32'(rst_hi_b), 32'd1);
        chk32({tag, "_done_count"}, 32'(done_rise_b), 32'd1);
        chk1({tag, "_busy"}, busy_b, 1'b0);
        chk1({tag, "_done"}, done_b, 1'b1);
        for (int i = 0; i < 3; i++) chk32({tag, "_reads_addr"}, 32'(rd_cnt_b[i]), 32'd1);
        chk32({tag, "_bad_reads"}, 32'(bad_rd_b), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int not_once;
        img_b[0] = 16'h0001; img_b[1] = 16'h8000; img_b[2] = 16'h00FF;
        bad_rd_a = 0; rd_tot_a = 0; den_cnt_a = 0; den_rise_a = 0; rst_hi_a = 0;
        for (int i = 0; i < 630; i++) rd_cnt_a[i] = 0;
        clr_b();
        den_prev_a = 1'b0; den_prev_b = 1'b0; done_prev_b = 1'b0;
        mem_data_a = '0; mem_data_b = '0;
        start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
        reset_n = 1'b0;
        tick(3);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_done", done_a, 1'b0);
        chk1("rst_den", io_den_a, 1'b0);
        chk1("rst_mem_rd", mem_rd_a, 1'b0);
        chk1("rst_io_reset", io_reset_b, 1'b0);
        chk1("rst_busy_b", busy_b, 1'b0);
        reset_n = 1'b1;
        tick(1);

        // Full-size image, 0xA5C3 in every word
        for (int i = 0; i < 10080; i++) exp_a.push_back(w_a[i % 16]);
        start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        chk1("a_busy_e0", busy_a, 1'b1);
        chk1("a_fetch_rd", mem_rd_a, 1'b1);
        chk32("a_fetch_addr", 32'(mem_addr_a), 32'd0);
        chk1("a_fetch_den", io_den_a, 1'b0);
        tick(1);
        chk1("a_prime_rd", mem_rd_a, 1'b0);
        chk1("a_prime_den", io_den_a, 1'b0);
        tick(1);
        chk1("a_shift_den", io_den_a, 1'b1);
        chk1("a_prefetch_rd", mem_rd_a, 1'b1);
        chk32("a_prefetch_addr", 32'(mem_addr_a), 32'd1);
        c = 0;
        while (!done_a && c < 11000) begin
            tick(1);
            c++;
        end
        chk1("a_done_timeout", done_a, 1'b1);
        tick(2);
        chk32("a_den_cycles", 32'(den_cnt_a), 32'd10080);
        chk32("a_den_runs", 32'(den_rise_a), 32'd1);
        chk32("a_bits_left", 32'(exp_a.size()), 32'd0);
        chk32("a_reset_cycles", 32'(rst_hi_a), 32'd1);
        chk1("a_busy_end", busy_a, 1'b0);
        chk1("a_done_end", done_a, 1'b1);
        chk32("a_total_reads", 32'(rd_tot_a), 32'd630);
        chk32("a_bad_reads", 32'(bad_rd_a), 32'd0);
        not_once = 0;
        for (int i = 0; i < 630; i++) if (rd_cnt_a[i] != 1) not_once++;
        chk32("a_addr_not_once", 32'(not_once), 32'd0);

        // 40-bit image {0001, 8000, 00FF}
        clr_b(); push_b(40);
        pulse_start_b();
        wait_done_b(100);
        check_full_b("b_full");

        // Abort while bit 20 is on io_dta
        clr_b(); push_b(21);
        pulse_start_b();
        tick(22);
        abort_b = 1'b1;
        tick(1);
        abort_b = 1'b0;
        chk1("abort_den", io_den_b, 1'b0);
        chk1("abort_busy", busy_b, 1'b0);
        chk1("abort_done", done_b, 1'b0);
        chk1("abort_mem_rd", mem_rd_b, 1'b0);
        tick(3);
        chk32("abort_reset_cycles", 32'(rst_hi_b), 32'd0);
        chk32("abort_den_cycles", 32'(den_cnt_b), 32'd21);
        chk32("abort_bits_left", 32'(exp_b.size()), 32'd0);
        chk1("abort_done_later", done_b, 1'b0);
        clr_b(); push_b(40);
        pulse_start_b();
        wait_done_b(100);
        check_full_b("b_after_abort");

        // start re-pulsed at bits 5 and 30 must be ignored
        clr_b(); push_b(40);
        pulse_start_b();
        tick(7);
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        tick(24);
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        wait_done_b(100);
        check_full_b("b_restart_ignored");

        // Asynchronous reset between edges while the word-2 prefetch is on the bus
        clr_b(); push_b(17);
        pulse_start_b();
        tick(18);
        chk1("areset_pre_rd", mem_rd_b, 1'b1);
        #6;
        reset_n = 1'b0;
        #1;
        chk1("areset_den", io_den_b, 1'b0);
        chk1("areset_busy", busy_b, 1'b0);
        chk1("areset_mem_rd", mem_rd_b, 1'b0);
        chk1("areset_dta", io_dta_b, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(3);
        chk1("areset_idle_busy", busy_b, 1'b0);
        chk1("areset_idle_done", done_b, 1'b0);
        chk1("areset_idle_rd", mem_rd_b, 1'b0);
        chk1("areset_idle_den", io_den_b, 1'b0);
        chk32("areset_bits_left", 32'(exp_b.size()), 32'd0);
        chk32("areset_reset_cycles", 32'(rst_hi_b), 32'd0);

        // start and abort together in IDLE: abort wins
        clr_b();
        start_b = 1'b1; abort_b = 1'b1;
        tick(1);
        start_b = 1'b0; abort_b = 1'b0;
        chk1("sa_busy", busy_b, 1'b0);
        chk1("sa_mem_rd", mem_rd_b, 1'b0);
        tick(2);
        chk1("sa_busy_later", busy_b, 1'b0);
        chk1("sa_den_later", io_den_b, 1'b0);
        clr_b(); push_b(40);
        pulse_start_b();
        chk1("sa_start_busy", busy_b, 1'b1);
        chk1("sa_start_rd", mem_rd_b, 1'b1);
        wait_done_b(100);
        check_full_b("b_after_sa");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bitstream_loader.md
Name: bitstream_loader

Overview:
- Transmit side of the FPGACore serial programming interface.
- Reads a configuration image from a word-wide synchronous memory and shifts it out one bit per clock on io_dta, qualified by io_den.
- After the last bit it issues a one-cycle io_reset pulse to clear the lookup tables.
- Sits between the boot ROM/config RAM and FPGACore; FPGACore samples io_dta on every clk rising edge while io_den is high.

Parameters:
- BITS, 10080, total bitstream length in bits (must be >= 1).
- WORD_W, 16, memory word width (must be >= 2).
- ADDR_W, 10, memory address width (2^ADDR_W >= ceil(BITS/WORD_W)).

Ports:
- clk  in  1  clock shared with FPGACore.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled only in IDLE.
- abort  in  1  cancel a load in progress.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory word address.
- mem_data  in  WORD_W  read data, valid the cycle after mem_rd is high.
- io_dta  out  1  serial configuration data to FPGACore.
- io_den  out  1  data enable to FPGACore.
- io_reset  out  1  LUT reset pulse to FPGACore.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; internal counters and buffers cleared. Assertion mid-load drops io_den immediately. No resume after reset; a new start is required.
- All outputs are registered.
- Bit order:
  - Stream bit i = word (i / WORD_W), bit (i % WORD_W), LSB first.
  - Words read = ceil(BITS/WORD_W).
  - In the final partial word, only the low BITS % WORD_W bits are sent.
- States: IDLE, FETCH, PRIME, SHIFT, PULSE.
- IDLE:
  - start=1 and abort=0 at edge E0 -> FETCH. Also at E0: busy=1, done=0.
  - start while busy is ignored.
- FETCH (cycle 1 after E0): mem_rd=1, mem_addr=0 -> PRIME.
- PRIME (cycle 2): mem_data captured into shift register at end of cycle -> SHIFT.
- SHIFT:
  - io_den=1 from cycle 3 for exactly BITS consecutive cycles.
  - io_dta = current bit; shifts each cycle.
  - No gaps between words.
- Prefetch:
  - In the cycle where word k bit 0 is on io_dta, mem_rd=1 with mem_addr=k+1, only if word k+1 exists.
  - mem_data is captured into a holding register the next cycle.
  - The holding register loads the shift register after bit WORD_W-1 of word k.
  - Exactly one read per word; no read beyond the last word.
  - mem_addr holds its last value when mem_rd=0.
- End of stream:
  - After the BITS-th bit, the next cycle has io_den=0, io_dta=0, io_reset=1 (state PULSE), for exactly one cycle.
  - Following cycle: io_reset=0, busy=0, done=1, state IDLE.
  - done holds until the next accepted start.
- io_dta is 0 whenever io_den=0.
- io_reset is never high while io_den is high.
- abort:
  - abort=1 in any busy state -> next cycle io_den=0, io_dta=0, mem_rd=0, io_reset=0, busy=0, done=0, IDLE. No LUT reset pulse is issued.
  - abort in the same cycle as the final bit or during PULSE still aborts: done stays 0.
  - start and abort together in IDLE: abort wins, remain IDLE.
- Counters:
  - Bit counter spans 0..BITS-1 (width clog2(BITS+1)).
  - Word counter spans 0..ceil(BITS/WORD_W)-1.
  - No wrap-around; both reset to 0 on each start.

Test Plan:
- Default params, memory filled with 16'hA5C3 repeated, start pulse -> io_den high for exactly 10080 consecutive cycles starting 3 edges after start. Captured serial stream equals the image LSB-first. 630 reads at addresses 0..629, each exactly once. One io_reset pulse, then done=1, busy=0.
- BITS=40, WORD_W=16, mem = {16'h0001, 16'h8000, 16'h00FF} -> 40 io_den cycles.
  - Bit 0 = 1, bits 1..30 = 0, bit 31 = 1, bits 32..39 = 1.
  - Reads only to addresses 0..2.
- BITS=40, abort asserted at bit 20 -> io_den falls the next cycle, no io_reset pulse, done=0, busy=0. A subsequent start performs a full 40-bit load.
- start pulsed again at bits 5 and 30 during a load -> ignored. Stream and length are unchanged; only one done.
- reset driven low asynchronously mid-SHIFT (between edges) -> io_den, busy, mem_rd drop to 0 immediately. After release the block is IDLE with done=0.
- start and abort high simultaneously in IDLE -> no mem_rd, busy stays 0. A later start alone begins the load normally.
